datapath_seq: RTL and testbench

Parametrised, self-sequencing successor to the 16-bit CPU datapath. Holds a register file with two read ports, operand registers A/B, a shifter, a 4-function ALU, a result register C and N/V/Z status flags. Internal control replaces the external load strobes: each instruction is accepted over a valid/ready handshake, then sequenced through read, execute and writeback. It sits between the instruction decoder/FSM and memory, and has the same role as the existing datapath.

---
 rtl/datapath_seq_if.sv | 44 ++++
 rtl/datapath_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_datapath_seq.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_seq_if.sv
// Instruction/result bus between the decoder sequencer and datapath_seq.
interface datapath_seq_if #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned NREGS    = 8,
    parameter int unsigned PC_WIDTH = 9
);
    localparam int unsigned RW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic                op_valid;
    logic                op_ready;
    logic [1:0]          op_kind;
    logic [1:0]          alu_op;
    logic [1:0]          shift;
    logic [RW-1:0]       rn;
    logic [RW-1:0]       rm;
    logic [RW-1:0]       rd;
    logic                asel;
    logic                bsel;
    logic                wb_en;
    logic                loads;
    logic [WIDTH-1:0]    sximm5;
    logic [WIDTH-1:0]    sximm8;
    logic [WIDTH-1:0]    mdata;
    logic [PC_WIDTH-1:0] PC;
    logic                done;
    logic [WIDTH-1:0]    out;
    logic                N;
    logic                V;
    logic                Z;

    // Decoder side: offers instructions, observes results.
    modport master (
        output op_valid, op_kind, alu_op, shift, rn, rm, rd,
               asel, bsel, wb_en, loads, sximm5, sximm8, mdata, PC,
        input  op_ready, done, out, N, V, Z
    );

    // Datapath side.
    modport slave (
        input  op_valid, op_kind, alu_op, shift, rn, rm, rd,
               asel, bsel, wb_en, loads, sximm5, sximm8, mdata, PC,
        output op_ready, done, out, N, V, Z
    );
endinterface

// File: rtl/datapath_seq.sv
// Self-sequencing datapath: register file, A/B operand registers, shifter,
// 4-function ALU, result register C and N/V/Z flags. One instruction at a
// time is accepted over op_valid/op_ready and walked through READ/EXEC/WB.
module datapath_seq #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned NREGS    = 8,
    parameter int unsigned PC_WIDTH = 9
) (
    input  logic          clk,
    input  logic          reset_n,
    datapath_seq_if.slave bus
);
    localparam int unsigned RW  = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [1:0] K_ALU  = 2'd0;
    localparam logic [1:0] K_IMM  = 2'd1;
    localparam logic [1:0] K_MEM  = 2'd2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;

    localparam logic [1:0] SH_LSL = 2'b01;
    localparam logic [1:0] SH_LSR = 2'b10;
    localparam logic [1:0] SH_ASR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    // Latched instruction; wval is the writeback source for IMM/MEM/LINK,
    // chosen at accept so the raw sximm8/mdata/PC need not be kept.
    typedef struct packed {
        logic [1:0]       kind;
        logic [1:0]       alu_op;
        logic [1:0]       shift;
        logic [RW-1:0]    rn;
        logic [RW-1:0]    rm;
        logic [RW-1:0]    rd;
        logic             asel;
        logic             bsel;
        logic             wb_en;
        logic             loads;
        logic [WIDTH-1:0] sximm5;
        logic [WIDTH-1:0] wval;
    } cmd_t;

    state_t           state_q;
    state_t           state_d;
    cmd_t             cmd_q;
    cmd_t             cmd_in;
    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] c_q;
    logic             n_q;
    logic             v_q;
    logic             z_q;
    logic             done_q;
    logic             ready_q;

    logic             accept_c;
    logic             load_ab_c;
    logic             load_c_c;
    logic             load_flags_c;
    logic             reg_we_c;
    logic [WIDTH-1:0] reg_wdata_c;
    logic             done_d;
    logic             ready_d;

    logic [WIDTH-1:0] b_sh_c;
    logic [WIDTH-1:0] a_op_c;
    logic [WIDTH-1:0] b_op_c;
    logic [WIDTH-1:0] alu_c;
    logic             alu_v_c;

    // Command capture: gather the bus fields and pick the writeback source.
    always_comb begin
        cmd_in        = '0;
        cmd_in.kind   = bus.op_kind;
        cmd_in.alu_op = bus.alu_op;
        cmd_in.shift  = bus.shift;
        cmd_in.rn     = bus.rn;
        cmd_in.rm     = bus.rm;
        cmd_in.rd     = bus.rd;
        cmd_in.asel   = bus.asel;
        cmd_in.bsel   = bus.bsel;
        cmd_in.wb_en  = bus.wb_en;
        cmd_in.loads  = bus.loads;
        cmd_in.sximm5 = bus.sximm5;
        case (bus.op_kind)
            K_IMM:   cmd_in.wval = bus.sximm8;
            K_MEM:   cmd_in.wval = bus.mdata;
            default: cmd_in.wval = WIDTH'(bus.PC);
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: ALU ops take READ/EXEC, the load-style ops go straight to WB.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.op_valid) begin
                    state_d = (bus.op_kind == K_ALU) ? S_READ : S_WB;
                end
            end
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/control decode: datapath enables plus next values of done/op_ready.
    always_comb begin
        accept_c     = 1'b0;
        load_ab_c    = 1'b0;
        load_c_c     = 1'b0;
        load_flags_c = 1'b0;
        reg_we_c     = 1'b0;
        reg_wdata_c  = cmd_q.wval;
        done_d       = (state_d == S_WB);
        ready_d      = (state_d == S_IDLE);
        case (state_q)
            S_IDLE: accept_c = bus.op_valid;
            S_READ: load_ab_c = 1'b1;
            S_EXEC: begin
                load_c_c     = 1'b1;
                load_flags_c = cmd_q.loads;
            end
            S_WB: begin
                if (cmd_q.kind == K_ALU) begin
                    reg_we_c    = cmd_q.wb_en;
                    reg_wdata_c = c_q;
                end else begin
                    reg_we_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Shifter on B, operand selection and ALU with signed-overflow detect.
    always_comb begin
        case (cmd_q.shift)
            SH_LSL:  b_sh_c = {b_q[MSB-1:0], 1'b0};
            SH_LSR:  b_sh_c = {1'b0, b_q[MSB:1]};
            SH_ASR:  b_sh_c = {b_q[MSB], b_q[MSB:1]};
            default: b_sh_c = b_q;
        endcase
        a_op_c  = cmd_q.asel ? '0 : a_q;
        b_op_c  = cmd_q.bsel ? cmd_q.sximm5 : b_sh_c;
        alu_v_c = 1'b0;
        case (cmd_q.alu_op)
            OP_ADD: begin
                alu_c   = a_op_c + b_op_c;
                alu_v_c = (a_op_c[MSB] == b_op_c[MSB]) && (alu_c[MSB] != a_op_c[MSB]);
            end
            OP_SUB: begin
                alu_c   = a_op_c - b_op_c;
                alu_v_c = (a_op_c[MSB] != b_op_c[MSB]) && (alu_c[MSB] != a_op_c[MSB]);
            end
            OP_AND:  alu_c = a_op_c & b_op_c;
            default: alu_c = ~b_op_c;
        endcase
    end

    // Command register, handshake outputs, operand/result registers and flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            done_q  <= done_d;
            ready_q <= ready_d;
            if (accept_c) begin
                cmd_q <= cmd_in;
            end
            if (load_ab_c) begin
                a_q <= regs[cmd_q.rn];
                b_q <= regs[cmd_q.rm];
            end
            if (load_c_c) begin
                c_q <= alu_c;
            end
            if (load_flags_c) begin
                n_q <= alu_c[MSB];
                v_q <= alu_v_c;
                z_q <= (alu_c == '0);
            end
        end
    end

    // Register file; a reset mid-instruction abandons the pending write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_we_c) begin
            regs[cmd_q.rd] <= reg_wdata_c;
        end
    end

    assign bus.op_ready = ready_q;
    assign bus.done     = done_q;
    assign bus.out      = c_q;
    assign bus.N        = n_q;
    assign bus.V        = v_q;
    assign bus.Z        = z_q;
endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq at WIDTH=16, NREGS=8, PC_WIDTH=9.
module tb_datapath_seq;
    localparam int unsigned W  = 16;
    localparam int unsigned NR = 8;
    localparam int unsigned PW = 9;

    localparam logic [1:0] K_ALU = 2'd0, K_IMM = 2'd1, K_MEM = 2'd2, K_LINK = 2'd3;
    localparam logic [1:0] A_ADD = 2'b00, A_SUB = 2'b01, A_AND = 2'b10, A_NOT = 2'b11;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   lat;
    int   dones;
    logic [W-1:0] v;

    always #5 clk = ~clk;

    datapath_seq_if #(.WIDTH(W), .NREGS(NR), .PC_WIDTH(PW)) bus ();

    datapath_seq #(.WIDTH(W), .NREGS(NR), .PC_WIDTH(PW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic n, input logic vv, input logic z);
        chk(tag, {29'd0, bus.N, bus.V, bus.Z}, {29'd0, n, vv, z});
    endtask

    // Offer the instruction already on the bus; returns negedges from accept to done.
    // Fields are scrambled after accept to show they were latched.
    task automatic issue(input bit hold, output int l);
        int n = 0;
        bus.op_valid = 1'b1;
        while (!bus.op_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.op_ready) chk("accept_timeout", 32'(bus.op_ready), 32'd1);
        @(posedge clk);
        l = 0;
        do begin
            @(negedge clk);
            l++;
            if (l == 1) begin
                bus.rn = ~bus.rn; bus.rm = ~bus.rm; bus.rd = ~bus.rd;
                bus.alu_op = ~bus.alu_op; bus.shift = ~bus.shift;
                bus.sximm5 = ~bus.sximm5; bus.sximm8 = '0; bus.mdata = '0; bus.PC = '0;
                bus.op_kind = ~bus.op_kind; bus.wb_en = ~bus.wb_en; bus.loads = ~bus.loads;
            end
            if (!hold) bus.op_valid = 1'b0;
        end while (!bus.done && l < 10);
        bus.op_valid = 1'b0;
        if (!bus.done) chk("done_timeout", 32'(bus.done), 32'd1);
        @(negedge clk);
    endtask

    task automatic do_alu(input logic [1:0] op, input logic [1:0] sh, input logic [2:0] rn,
                          input logic [2:0] rm, input logic [2:0] rd, input logic asel,
                          input logic bsel, input logic wb, input logic ld,
                          input logic [W-1:0] imm5, input bit hold, output int l);
        bus.op_kind = K_ALU; bus.alu_op = op; bus.shift = sh;
        bus.rn = rn; bus.rm = rm; bus.rd = rd; bus.asel = asel; bus.bsel = bsel;
        bus.wb_en = wb; bus.loads = ld; bus.sximm5 = imm5;
        issue(hold, l);
    endtask

    task automatic do_ld(input logic [1:0] kind, input logic [2:0] rd, input logic wb,
                         input logic [W-1:0] imm8, input logic [W-1:0] md,
                         input logic [PW-1:0] pc, output int l);
        bus.op_kind = kind; bus.rd = rd; bus.wb_en = wb; bus.loads = 1'b1;
        bus.sximm8 = imm8; bus.mdata = md; bus.PC = pc;
        bus.alu_op = A_ADD; bus.shift = 2'b00; bus.rn = 3'd0; bus.rm = 3'd0;
        bus.asel = 1'b0; bus.bsel = 1'b0; bus.sximm5 = '0;
        issue(1'b0, l);
    endtask

    // Read R[r] through the ALU (0 + R[r]) without touching flags or registers.
    task automatic peek(input logic [2:0] r, output logic [W-1:0] val);
        int l;
        do_alu(A_ADD, 2'b00, 3'd0, r, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, l);
        val = bus.out;
    endtask

    initial begin
        bus.op_valid = 1'b0; bus.op_kind = '0; bus.alu_op = '0; bus.shift = '0;
        bus.rn = '0; bus.rm = '0; bus.rd = '0; bus.asel = 1'b0; bus.bsel = 1'b0;
        bus.wb_en = 1'b0; bus.loads = 1'b0; bus.sximm5 = '0; bus.sximm8 = '0;
        bus.mdata = '0; bus.PC = '0;

        repeat (3) @(negedge clk);
        chk("rst_out", 32'(bus.out), 32'h0);
        chk_flags("rst_flags", 1'b0, 1'b0, 1'b0);
        chk("rst_ready", 32'(bus.op_ready), 32'd1);
        chk("rst_done", 32'(bus.done), 32'd0);
        reset_n = 1'b1;

        // Basic add with lsl1 on B: 7 + (2<<1) = 11
        do_ld(K_IMM, 3'd0, 1'b1, 16'd7, 16'hAAAA, 9'h155, lat);
        chk("imm_latency", 32'(lat), 32'd1);
        do_ld(K_IMM, 3'd1, 1'b1, 16'd2, 16'h5555, 9'h0AA, lat);
        do_alu(A_ADD, 2'b01, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, '0, 1'b0, lat);
        chk("alu_latency", 32'(lat), 32'd3);
        chk("add_lsl_out", 32'(bus.out), 32'd11);
        chk_flags("add_lsl_flags", 1'b0, 1'b0, 1'b0);
        peek(3'd2, v);
        chk("add_lsl_r2", 32'(v), 32'd11);

        // Signed overflow on add, then zero result on sub
        do_ld(K_IMM, 3'd0, 1'b1, 16'h7FFF, 16'h0, 9'h0, lat);
        do_ld(K_IMM, 3'd1, 1'b1, 16'h0001, 16'h0, 9'h0, lat);
        do_alu(A_ADD, 2'b00, 3'd0, 3'd1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, '0, 1'b0, lat);
        chk("add_ovf_out", 32'(bus.out), 32'h8000);
        chk_flags("add_ovf_flags", 1'b1, 1'b1, 1'b0);
        do_alu(A_SUB, 2'b00, 3'd1, 3'd1, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, '0, 1'b0, lat);
        chk("sub_zero_out", 32'(bus.out), 32'h0);
        chk_flags("sub_zero_flags", 1'b0, 1'b0, 1'b1);

        // Compare-only sub (wb_en=0): 1 - 0x7FFF = 0x8002, R5 untouched
        do_ld(K_IMM, 3'd5, 1'b1, 16'h1234, 16'h0, 9'h0, lat);
        do_alu(A_SUB, 2'b00, 3'd1, 3'd0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0, lat);
        chk("cmp_out", 32'(bus.out), 32'h8002);
        chk_flags("cmp_flags", 1'b1, 1'b0, 1'b0);
        peek(3'd5, v);
        chk("cmp_r5_kept", 32'(v), 32'h1234);
        // loads=0: 0x7FFF+0x7FFF would set V, flags must hold
        do_alu(A_ADD, 2'b00, 3'd0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, lat);
        chk("noload_out", 32'(bus.out), 32'hFFFE);
        chk_flags("noload_flags", 1'b1, 1'b0, 1'b0);

        // not of sximm5 with A forced to 0
        do_alu(A_NOT, 2'b00, 3'd3, 3'd3, 3'd6, 1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFD, 1'b0, lat);
        chk("not_imm5_out", 32'(bus.out), 32'h0002);
        chk_flags("not_imm5_flags", 1'b0, 1'b0, 1'b0);

        // Shifter: lsr1 zero-fills, asr1 sign-fills
        do_ld(K_IMM, 3'd7, 1'b1, 16'h8004, 16'h0, 9'h0, lat);
        do_alu(A_ADD, 2'b10, 3'd0, 3'd7, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, lat);
        chk("lsr_out", 32'(bus.out), 32'h4002);
        do_alu(A_ADD, 2'b11, 3'd0, 3'd7, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, lat);
        chk("asr_out", 32'(bus.out), 32'hC002);
        // neg - pos giving positive: 0x8004 - 0x7FFF = 0x0005, V=1
        do_alu(A_SUB, 2'b00, 3'd7, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0, lat);
        chk("sub_ovf_out", 32'(bus.out), 32'h0005);
        chk_flags("sub_ovf_flags", 1'b0, 1'b1, 1'b0);
        // and clears V: 0x8004 & asr(0x8004)=0xC002 -> 0x8000
        do_alu(A_AND, 2'b11, 3'd7, 3'd7, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, '0, 1'b0, lat);
        chk("and_out", 32'(bus.out), 32'h8000);
        chk_flags("and_flags", 1'b1, 1'b0, 1'b0);

        // LINK, MEM, and IMM with wb_en=0 (still written); C and flags untouched
        do_ld(K_LINK, 3'd6, 1'b1, 16'h1111, 16'h2222, 9'h1A5, lat);
        chk("link_latency", 32'(lat), 32'd1);
        chk("link_out_kept", 32'(bus.out), 32'h8000);
        chk_flags("link_flags_kept", 1'b1, 1'b0, 1'b0);
        peek(3'd6, v);
        chk("link_r6", 32'(v), 32'h01A5);
        do_ld(K_MEM, 3'd5, 1'b1, 16'h1111, 16'hBEEF, 9'h0, lat);
        do_ld(K_IMM, 3'd4, 1'b0, 16'hFFA0, 16'h3333, 9'h0, lat);
        peek(3'd5, v);
        chk("mem_r5", 32'(v), 32'hBEEF);
        peek(3'd4, v);
        chk("imm_nowb_r4", 32'(v), 32'hFFA0);

        // op_valid held through the whole instruction: exactly one accept
        do_alu(A_ADD, 2'b00, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, lat);
        chk("hold_latency", 32'(lat), 32'd3);
        chk("hold_out", 32'(bus.out), 32'h8000);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("hold_extra_done", 32'(dones), 32'd0);
        peek(3'd2, v);
        chk("hold_r2", 32'(v), 32'h8000);

        // Reset asserted in EXEC of add R0+R1 -> R5
        bus.op_kind = K_ALU; bus.alu_op = A_ADD; bus.shift = 2'b00;
        bus.rn = 3'd0; bus.rm = 3'd1; bus.rd = 3'd5; bus.asel = 1'b0; bus.bsel = 1'b0;
        bus.wb_en = 1'b1; bus.loads = 1'b1;
        bus.op_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.op_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out", 32'(bus.out), 32'h0);
        chk_flags("mid_rst_flags", 1'b0, 1'b0, 1'b0);
        chk("mid_rst_ready", 32'(bus.op_ready), 32'd1);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("mid_rst_no_wb", 32'(dones), 32'd0);
        peek(3'd5, v);
        chk("mid_rst_r5", 32'(v), 32'h0);
        do_ld(K_IMM, 3'd1, 1'b1, 16'h0055, 16'h0, 9'h0, lat);
        peek(3'd1, v);
        chk("post_rst_r1", 32'(v), 32'h0055);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
